// File: rtl/jumpy_hawk_pkg.sv
// Shared definitions for the jumpy hawk game datapath.
//   SCREEN_W / SCREEN_H : visible area of the 160x120 VGA adapter
//   COLOUR_*            : 3-bit adapter colours used by the sprites
//   state_t             : frame sequencer states of sprite_draw_scheduler
package jumpy_hawk_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BLACK  = 3'b000;
  localparam logic [2:0] COLOUR_GREEN  = 3'b010;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ERASE_BIRD,
    ERASE_WALL,
    DRAW_WALL,
    DRAW_BIRD,
    DONE
  } state_t;

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker: one pixel coordinate per clock.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : load base/size and restart at column 0, row 0
//   base_x/base_y: top-left corner of the box
//   w/h          : box size in pixels (both >= 1)
//   px/py        : current pixel, 9 bits wide so off-screen values never wrap
//   last         : current pixel is the final one of the box
// After start, the first pixel is presented in the following cycle and the
// walk advances every clock; the owner reloads it before stepping past last.
module rect_scanner (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [7:0] w,
  input  logic [7:0] h,
  output logic [8:0] px,
  output logic [8:0] py,
  output logic       last
);

  logic [7:0] bx_q;
  logic [6:0] by_q;
  logic [7:0] w_q;
  logic [7:0] h_q;
  logic [7:0] col_q;
  logic [7:0] row_q;
  logic       row_end;

  assign row_end = (col_q == w_q - 8'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      bx_q  <= '0;
      by_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (start) begin
      bx_q  <= base_x;
      by_q  <= base_y;
      w_q   <= w;
      h_q   <= h;
      col_q <= '0;
      row_q <= '0;
    end else if (row_end) begin
      col_q <= '0;
      row_q <= row_q + 8'd1;
    end else begin
      col_q <= col_q + 8'd1;
    end
  end

  assign px   = {1'b0, bx_q} + {1'b0, col_q};
  assign py   = {2'b00, by_q} + {1'b0, row_q};
  assign last = row_end && (row_q == h_q - 8'd1);

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame pixel sequencer for the VGA adapter plot port. On frame_tick it
// latches the bird/wall positions, erases last frame's bird and wall in the
// background colour, then draws the wall (gap left unplotted) and the bird on
// top of it. One pixel per clock; off-screen pixels still take their cycle.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   frame_tick            : one-cycle frame request
//   bird_x/bird_y         : bird top-left, sampled only in LATCH
//   wall_x/gap_y          : wall left column and gap top row, sampled in LATCH
//   x/y/colour/plot       : registered plot port to the adapter
//   busy                  : high from LATCH through DONE
//   frame_done            : one-cycle pulse in DONE
//   overrun               : one-cycle pulse after a tick that was dropped
//   collision             : bird hit the wall this frame (sticky until LATCH)
//   state_dbg             : current sequencer state
// Build option: SPRITE_DRAW_COLLISION_EN enables the collision detector;
// without it collision is tied low.
// Handshake: none; frame_tick is accepted only in IDLE, any tick seen while
// busy is dropped and reported on overrun, never queued.
module sprite_draw_scheduler
  import jumpy_hawk_pkg::*;
#(
  parameter int         BIRD_W      = 4,
  parameter int         BIRD_H      = 4,
  parameter int         WALL_W      = 6,
  parameter int         GAP_H       = 30,
  parameter logic [2:0] BIRD_COLOUR = COLOUR_YELLOW,
  parameter logic [2:0] WALL_COLOUR = COLOUR_GREEN,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BLACK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       collision,
  output state_t     state_dbg
);

  localparam logic [7:0] BIRD_W8   = 8'(BIRD_W);
  localparam logic [7:0] BIRD_H8   = 8'(BIRD_H);
  localparam logic [7:0] WALL_W8   = 8'(WALL_W);
  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);
  localparam logic [8:0] WALL_W9   = 9'(WALL_W);
  localparam logic [8:0] GAP_H9    = 9'(GAP_H);
  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);

  state_t     state_q, state_d;
  logic       prev_valid_q;
  logic [7:0] cur_bird_x_q, cur_wall_x_q, prev_wall_x_q;
  logic [6:0] cur_bird_y_q, cur_gap_y_q;

  logic       scan_start;
  logic [7:0] ld_x, ld_w, ld_h;
  logic [6:0] ld_y;
  logic [8:0] px, py;
  logic       scan_last;

  logic       in_phase, on_screen, in_gap;
  logic       pix_plot;
  logic [2:0] pix_colour;
  logic [8:0] gap_lo, gap_hi;

  rect_scanner u_scan (
    .clock  (clock),
    .reset  (reset),
    .start  (scan_start),
    .base_x (ld_x),
    .base_y (ld_y),
    .w      (ld_w),
    .h      (ld_h),
    .px     (px),
    .py     (py),
    .last   (scan_last)
  );

  // Next state, plus the scanner reload for the phase about to begin. The
  // scanner is loaded one cycle ahead so its first pixel is ready on the
  // first cycle of the new phase and phases abut without a bubble.
  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    ld_x       = cur_wall_x_q;
    ld_y       = 7'd0;
    ld_w       = WALL_W8;
    ld_h       = SCREEN_H8;
    case (state_q)
      IDLE: if (frame_tick) state_d = LATCH;
      LATCH: begin
        scan_start = 1'b1;
        if (prev_valid_q) begin
          // cur_* still hold last frame's bird during this cycle
          state_d = ERASE_BIRD;
          ld_x    = cur_bird_x_q;
          ld_y    = cur_bird_y_q;
          ld_w    = BIRD_W8;
          ld_h    = BIRD_H8;
        end else begin
          state_d = DRAW_WALL;
          ld_x    = wall_x;
        end
      end
      ERASE_BIRD: if (scan_last) begin
        state_d    = ERASE_WALL;
        scan_start = 1'b1;
        ld_x       = prev_wall_x_q;
      end
      ERASE_WALL: if (scan_last) begin
        state_d    = DRAW_WALL;
        scan_start = 1'b1;
      end
      DRAW_WALL: if (scan_last) begin
        state_d    = DRAW_BIRD;
        scan_start = 1'b1;
        ld_x       = cur_bird_x_q;
        ld_y       = cur_bird_y_q;
        ld_w       = BIRD_W8;
        ld_h       = BIRD_H8;
      end
      DRAW_BIRD: if (scan_last) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign in_phase  = (state_q == ERASE_BIRD) || (state_q == ERASE_WALL) ||
                     (state_q == DRAW_WALL)  || (state_q == DRAW_BIRD);
  assign on_screen = (px < SCREEN_W9) && (py < SCREEN_H9);
  assign gap_lo    = {2'b00, cur_gap_y_q};
  assign gap_hi    = gap_lo + GAP_H9;
  assign in_gap    = (py >= gap_lo) && (py < gap_hi);

  always_comb begin
    pix_plot   = 1'b0;
    pix_colour = BG_COLOUR;
    case (state_q)
      ERASE_BIRD, ERASE_WALL: pix_plot = on_screen;
      DRAW_WALL: begin
        pix_plot   = on_screen && !in_gap;
        pix_colour = WALL_COLOUR;
      end
      DRAW_BIRD: begin
        pix_plot   = on_screen;
        pix_colour = BIRD_COLOUR;
      end
      default: pix_plot = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_valid_q  <= 1'b0;
      cur_bird_x_q  <= '0;
      cur_bird_y_q  <= '0;
      cur_wall_x_q  <= '0;
      cur_gap_y_q   <= '0;
      prev_wall_x_q <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= BG_COLOUR;
      plot          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q <= state_d;
      overrun <= frame_tick && (state_q != IDLE);
      plot    <= pix_plot;
      if (in_phase) begin
        x      <= px[7:0];
        y      <= py[6:0];
        colour <= pix_colour;
      end
      if (state_q == LATCH) begin
        prev_wall_x_q <= cur_wall_x_q;
        cur_bird_x_q  <= bird_x;
        cur_bird_y_q  <= bird_y;
        cur_wall_x_q  <= wall_x;
        cur_gap_y_q   <= gap_y;
        prev_valid_q  <= 1'b1;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign state_dbg  = state_q;

`ifdef SPRITE_DRAW_COLLISION_EN
  logic collision_q;
  logic hit;

  // A visible bird pixel inside the wall column but outside the gap.
  assign hit = (state_q == DRAW_BIRD) && on_screen && !in_gap &&
               (px >= {1'b0, cur_wall_x_q}) &&
               (px < ({1'b0, cur_wall_x_q} + WALL_W9));

  always_ff @(posedge clock) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else if (state_q == LATCH) begin
      collision_q <= 1'b0;
    end else if (hit) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule
